wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max clocks a grant may go without an ack while a transfer is outstanding.
REQ-002 SHALL have port wb_clock_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_addr_i  input  3 x WB_ADDR_WIDTH  per-requester address (index 0 = video fetch, 1 = CPU, 2 = MCU).
REQ-005 SHALL have port req_data_i  input  3 x DATA_WIDTH  per-requester write data.
REQ-006 SHALL have ports req_we_i, req_cycle_i, req_strobe_i  input  3  per-requester Wishbone B4 controls.
REQ-007 SHALL have ports req_stall_o, req_ack_o  output  3  per-requester stall and ack.
REQ-008 SHALL have port req_data_o  output  DATA_WIDTH  read data broadcast to all requesters.
REQ-009 SHALL have ports wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o  output  WB_ADDR_WIDTH/DATA_WIDTH/1/1/1  shared-bus controller side.
REQ-010 SHALL have ports wb_data_i, wb_stall_i, wb_ack_i  input  DATA_WIDTH/1/1  shared-bus responses.
REQ-011 SHALL have port grant_o  output  2  registered grant index; 2'd3 = none.
REQ-012 SHALL have port timeout_o  output  1  one-clock pulse on forced release.

Function
REQ-013 SHALL implement states IDLE and GRANTED; IDLE -> GRANTED when any unmasked req_cycle_i is high, with the winner latched into grant_o at that edge.
REQ-014 SHALL give requester 0 absolute priority over 1 and 2.
REQ-015 SHALL hold the grant, with no preemption, while the granted req_cycle_i stays high.
REQ-016 SHALL, in GRANTED, combinationally route the granted requester's addr/data/we/cycle/strobe to wb_*_o, and route wb_stall_i/wb_ack_i to that requester only.
REQ-017 SHALL drive req_stall_o=1 and req_ack_o=0 to every non-granted requester, and to all requesters in IDLE.
REQ-018 SHALL drive wb_cycle_o=0 and wb_strobe_o=0 in IDLE.
REQ-019 SHALL always drive req_data_o = wb_data_i.
REQ-020 SHALL return GRANTED -> IDLE on the edge where the granted req_cycle_i is sampled low, leaving exactly one idle bus clock before the next grant; a request pending on that edge is arbitrated on the following edge.
REQ-021 SHALL keep an outstanding counter, width ceil(log2(TIMEOUT_CYCLES+1)): +1 on strobe&&!stall, -1 on ack, both on the same edge = no change, saturating at max and 0; cleared on every grant change.
REQ-022 SHALL keep a watchdog counter, cleared on grant and on each ack, incrementing while outstanding>0.
REQ-023 SHALL, when the watchdog reaches TIMEOUT_CYCLES: pulse timeout_o, enter IDLE, and mask that requester until its req_cycle_i is sampled low.
REQ-024 SHALL ignore a requester's cycle dropped with outstanding>0 (abort): counters clear, and late acks in IDLE reach no requester.
REQ-025 SHALL ignore req_strobe_i without req_cycle_i.

Reset
REQ-026 SHALL, while reset_i is high, asynchronously force state=IDLE, grant_o=2'd3, timeout_o=0, counters=0, masks=0, round-robin pointer=2, wb_cycle_o=0, wb_strobe_o=0.
REQ-027 SHALL, on reset asserted mid-transfer, drop wb_cycle_o without waiting for ack.

Configuration
REQ-028 SHALL, with ARB_ROUND_ROBIN_EN defined, arbitrate between requesters 1 and 2 by granting the one not most recently granted when both request; the pointer updates only on grants to 1 or 2.
REQ-029 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority 0 > 1 > 2 and omit the pointer logic.

Verification
REQ-030 SHALL cover: reset -> grant_o=3, wb_cycle_o=0, req_stall_o=3'b111.
REQ-031 SHALL cover: req 1 and req 2 cycle both rise at edge N -> grant_o=1 at N+1; without the macro, req 1 held again after release -> grant 1 again; with the macro -> grant 2.
REQ-032 SHALL cover: req 0 rises while 1 is granted mid-burst -> 1 keeps the grant until it drops cycle, then idle clock, then grant_o=0.
REQ-033 SHALL cover: CPU read of address 0x123 with wb_ack_i and wb_data_i=0xA5 one clock after the strobe -> req_ack_o=3'b010, req_data_o=0xA5, other acks 0.
REQ-034 SHALL cover: TIMEOUT_CYCLES=4, strobe accepted and no ack -> timeout_o pulses on the 4th clock, grant_o=3, requester masked until its cycle drops.
REQ-035 SHALL cover: reset_i asserted between edges during a grant -> wb_cycle_o=0 immediately, before the next edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// Three-requester Wishbone B4 arbiter: requester 0 has absolute priority, grants are held until the cycle drops.
// A watchdog force-releases a stuck grant. Define ARB_ROUND_ROBIN_EN to alternate between requesters 1 and 2.
module wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                          wb_clock_i,
  input  logic                          reset_i,
  input  logic [2:0][WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0][DATA_WIDTH-1:0]    req_data_i,
  input  logic [2:0]                    req_we_i,
  input  logic [2:0]                    req_cycle_i,
  input  logic [2:0]                    req_strobe_i,
  output logic [2:0]                    req_stall_o,
  output logic [2:0]                    req_ack_o,
  output logic [DATA_WIDTH-1:0]         req_data_o,
  output logic [WB_ADDR_WIDTH-1:0]      wb_addr_o,
  output logic [DATA_WIDTH-1:0]         wb_data_o,
  output logic                          wb_we_o,
  output logic                          wb_cycle_o,
  output logic                          wb_strobe_o,
  input  logic [DATA_WIDTH-1:0]         wb_data_i,
  input  logic                          wb_stall_i,
  input  logic                          wb_ack_i,
  output logic [1:0]                    grant_o,
  output logic                          timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] OUT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic [2:0]    mask_q, mask_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic          last2_q, last2_d;  // 1: requester 2 was granted most recently
`endif

  logic [2:0] cand, gnt_oh;
  logic [1:0] win;
  logic       accept;

  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      grant_q   <= 2'd3;
      timeout_q <= 1'b0;
      out_q     <= '0;
      wdog_q    <= '0;
      mask_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last2_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      out_q     <= out_d;
      wdog_q    <= wdog_d;
      mask_q    <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
      last2_q   <= last2_d;
`endif
    end
  end

  always_comb begin
    cand = req_cycle_i & ~mask_q;
    win  = 2'd3;
    if (cand[0])                win = 2'd0;
    else if (cand[1] && cand[2])
`ifdef ARB_ROUND_ROBIN_EN
                                win = last2_q ? 2'd1 : 2'd2;
`else
                                win = 2'd1;
`endif
    else if (cand[1])           win = 2'd1;
    else if (cand[2])           win = 2'd2;
  end

  assign accept = wb_strobe_o && !wb_stall_i;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    out_d     = out_q;
    wdog_d    = wdog_q;
    mask_d    = mask_q & req_cycle_i;
`ifdef ARB_ROUND_ROBIN_EN
    last2_d   = last2_q;
`endif
    case (state_q)
      IDLE: begin
        out_d  = '0;
        wdog_d = '0;
        if (|cand) begin
          state_d = GRANTED;
          grant_d = win;
`ifdef ARB_ROUND_ROBIN_EN
          if (win == 2'd1)      last2_d = 1'b0;
          else if (win == 2'd2) last2_d = 1'b1;
`endif
        end
      end
      GRANTED: begin
        if (!wb_cycle_o) begin
          state_d = IDLE;
          grant_d = 2'd3;
          out_d   = '0;
          wdog_d  = '0;
        end else if (out_q != '0 && !wb_ack_i && wdog_q == WD_LAST) begin
          // Forced release; requester stays locked out until it drops its cycle.
          state_d   = IDLE;
          grant_d   = 2'd3;
          timeout_d = 1'b1;
          out_d     = '0;
          wdog_d    = '0;
          mask_d    = mask_d | gnt_oh;
        end else begin
          if (accept && !wb_ack_i && out_q != OUT_MAX) out_d = out_q + CW'(1);
          else if (wb_ack_i && !accept && out_q != '0) out_d = out_q - CW'(1);
          if (wb_ack_i)          wdog_d = '0;
          else if (out_q != '0)  wdog_d = wdog_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_oh      = (state_q == GRANTED) ? (3'b001 << grant_q) : 3'b000;
    wb_addr_o   = '0;
    wb_data_o   = '0;
    wb_we_o     = 1'b0;
    wb_cycle_o  = 1'b0;
    wb_strobe_o = 1'b0;
    req_stall_o = 3'b111;
    req_ack_o   = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (gnt_oh[k]) begin
        wb_addr_o      = req_addr_i[k];
        wb_data_o      = req_data_i[k];
        wb_we_o        = req_we_i[k];
        wb_cycle_o     = req_cycle_i[k];
        wb_strobe_o    = req_strobe_i[k] & req_cycle_i[k];
        req_stall_o[k] = wb_stall_i;
        req_ack_o[k]   = wb_ack_i;
      end
    end
  end

  assign req_data_o = wb_data_i;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_wb_arbiter;
  localparam int T    = 4;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int CW   = $clog2(T + 1);
  localparam int OMAX = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [2:0][AW-1:0]    req_addr = '0;
  logic [2:0][DW-1:0]    req_data = '0;
  logic [2:0]            req_we = '0, req_cycle = '0, req_strobe = '0;
  logic [2:0]            req_stall_o, req_ack_o;
  logic [DW-1:0]         req_data_o, wb_data_o;
  logic [AW-1:0]         wb_addr_o;
  logic                  wb_we_o, wb_cycle_o, wb_strobe_o;
  logic [DW-1:0]         wb_data = '0;
  logic                  wb_stall = 1'b0, wb_ack = 1'b0;
  logic [1:0]            grant_o;
  logic                  timeout_o;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int       mg, mout, mwd, mto;
  bit [2:0] mmask;
`ifdef ARB_ROUND_ROBIN_EN
  int       mlast;
`endif

  wb_arbiter #(.TIMEOUT_CYCLES(T), .WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wb_clock_i(clk), .reset_i(rst),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_we_i(req_we),
    .req_cycle_i(req_cycle), .req_strobe_i(req_strobe),
    .req_stall_o(req_stall_o), .req_ack_o(req_ack_o), .req_data_o(req_data_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
    .wb_cycle_o(wb_cycle_o), .wb_strobe_o(wb_strobe_o),
    .wb_data_i(wb_data), .wb_stall_i(wb_stall), .wb_ack_i(wb_ack),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_cycle = '0; req_strobe = '0; req_we = '0;
    wb_stall = 1'b0; wb_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_cycle = 3'b111; req_strobe = 3'b111;
    @(negedge clk); #1;
    n_vec++; if (grant_o !== 2'd3) begin n_err++; $display("FAIL reset_grant got=%0d exp=3", grant_o); end
    n_vec++; if (wb_cycle_o !== 1'b0 || wb_strobe_o !== 1'b0) begin n_err++; $display("FAIL reset_bus got cyc=%b stb=%b exp 0 0", wb_cycle_o, wb_strobe_o); end
    n_vec++; if (req_stall_o !== 3'b111 || req_ack_o !== 3'b000) begin n_err++; $display("FAIL reset_stall got stall=%b ack=%b exp 111 000", req_stall_o, req_ack_o); end
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    idle_inputs();
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    logic [1:0] exp_again;
`ifdef ARB_ROUND_ROBIN_EN
    exp_again = 2'd2;
`else
    exp_again = 2'd1;
`endif
    req_cycle = 3'b110; tick();
    n_vec++; if (grant_o !== 2'd1) begin n_err++; $display("FAIL prio_first got=%0d exp=1", grant_o); end
    req_cycle = 3'b100; tick();
    n_vec++; if (grant_o !== 2'd3) begin n_err++; $display("FAIL prio_release got=%0d exp=3", grant_o); end
    req_cycle = 3'b110; tick();
    n_vec++; if (grant_o !== exp_again) begin n_err++; $display("FAIL prio_again got=%0d exp=%0d", grant_o, exp_again); end
    req_cycle = 3'b000; tick(); tick();
    n_vec++; if (grant_o !== 2'd3) begin n_err++; $display("FAIL prio_idle got=%0d exp=3", grant_o); end
  endtask

  task automatic test_no_preempt();
    req_cycle = 3'b010; tick();
    n_vec++; if (grant_o !== 2'd1) begin n_err++; $display("FAIL nopre_grant got=%0d exp=1", grant_o); end
    req_cycle = 3'b011; tick(); tick(); #1;
    n_vec++; if (grant_o !== 2'd1 || req_stall_o !== 3'b101) begin n_err++; $display("FAIL nopre_hold got grant=%0d stall=%b exp 1 101", grant_o, req_stall_o); end
    req_cycle = 3'b001; tick();
    n_vec++; if (grant_o !== 2'd3 || wb_cycle_o !== 1'b0) begin n_err++; $display("FAIL nopre_gap got grant=%0d cyc=%b exp 3 0", grant_o, wb_cycle_o); end
    tick();
    n_vec++; if (grant_o !== 2'd0) begin n_err++; $display("FAIL nopre_next got=%0d exp=0", grant_o); end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_read();
    req_addr[1] = 16'h0123; req_we = 3'b000;
    req_cycle = 3'b010; req_strobe = 3'b010; tick(); #1;
    n_vec++; if (grant_o !== 2'd1 || wb_addr_o !== 16'h0123 || wb_strobe_o !== 1'b1 || wb_we_o !== 1'b0) begin
      n_err++; $display("FAIL read_route got grant=%0d addr=%h stb=%b we=%b exp 1 0123 1 0", grant_o, wb_addr_o, wb_strobe_o, wb_we_o); end
    tick();
    req_strobe = 3'b000; wb_ack = 1'b1; wb_data = 8'hA5; #1;
    n_vec++; if (req_ack_o !== 3'b010) begin n_err++; $display("FAIL read_ack got=%b exp=010", req_ack_o); end
    n_vec++; if (req_data_o !== 8'hA5) begin n_err++; $display("FAIL read_data got=%h exp=a5", req_data_o); end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_timeout();
    req_cycle = 3'b100; req_strobe = 3'b100; tick();
    n_vec++; if (grant_o !== 2'd2) begin n_err++; $display("FAIL to_grant got=%0d exp=2", grant_o); end
    tick();
    req_strobe = 3'b000;
    for (int i = 1; i < T; i++) begin
      tick();
      n_vec++; if (timeout_o !== 1'b0 || grant_o !== 2'd2) begin n_err++; $display("FAIL to_early clk=%0d got to=%b grant=%0d exp 0 2", i, timeout_o, grant_o); end
    end
    tick();
    n_vec++; if (timeout_o !== 1'b1 || grant_o !== 2'd3) begin n_err++; $display("FAIL to_fire got to=%b grant=%0d exp 1 3", timeout_o, grant_o); end
    tick(); tick();
    n_vec++; if (timeout_o !== 1'b0 || grant_o !== 2'd3) begin n_err++; $display("FAIL to_masked got to=%b grant=%0d exp 0 3", timeout_o, grant_o); end
    req_cycle = 3'b000; tick();
    req_cycle = 3'b100; tick();
    n_vec++; if (grant_o !== 2'd2) begin n_err++; $display("FAIL to_unmask got=%0d exp=2", grant_o); end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_async_reset();
    req_cycle = 3'b010; req_strobe = 3'b010; tick(); #1;
    n_vec++; if (wb_cycle_o !== 1'b1) begin n_err++; $display("FAIL arst_pre got cyc=%b exp=1", wb_cycle_o); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (wb_cycle_o !== 1'b0 || wb_strobe_o !== 1'b0 || grant_o !== 2'd3) begin
      n_err++; $display("FAIL arst_drop got cyc=%b stb=%b grant=%0d exp 0 0 3", wb_cycle_o, wb_strobe_o, grant_o); end
    idle_inputs();
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic model_step();
    bit [2:0] nm, cand;
    bit       acc;
    int       prev;
    nm = mmask & req_cycle;
    if (mg == 3) begin
      cand = req_cycle & ~mmask;
      mto = 0; mout = 0; mwd = 0;
      if (cand[0]) mg = 0;
`ifdef ARB_ROUND_ROBIN_EN
      else if (cand[1] && cand[2]) mg = (mlast == 1) ? 2 : 1;
`else
      else if (cand[1] && cand[2]) mg = 1;
`endif
      else if (cand[1]) mg = 1;
      else if (cand[2]) mg = 2;
`ifdef ARB_ROUND_ROBIN_EN
      if (mg == 1 || mg == 2) mlast = mg;
`endif
    end else if (!req_cycle[mg]) begin
      mg = 3; mout = 0; mwd = 0; mto = 0;
    end else if (mout > 0 && !wb_ack && mwd + 1 == T) begin
      nm[mg] = 1'b1; mg = 3; mout = 0; mwd = 0; mto = 1;
    end else begin
      acc  = req_strobe[mg] && !wb_stall;
      prev = mout;
      if (acc && !wb_ack) mout = (mout < OMAX) ? mout + 1 : mout;
      else if (wb_ack && !acc && mout > 0) mout = mout - 1;
      if (wb_ack) mwd = 0;
      else if (prev > 0) mwd = mwd + 1;
      mto = 0;
    end
    mmask = nm;
  endtask

  task automatic test_random();
    logic [2:0]    e_stall, e_ack;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    idle_inputs();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    mg = 3; mout = 0; mwd = 0; mto = 0; mmask = '0;
`ifdef ARB_ROUND_ROBIN_EN
    mlast = 2;
`endif
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (req_cycle[k]) begin
          if ($urandom_range(7) == 0) req_cycle[k] = 1'b0;
        end else if ($urandom_range(3) == 0) req_cycle[k] = 1'b1;
        req_addr[k] = AW'($urandom);
        req_data[k] = DW'($urandom);
      end
      req_strobe = 3'($urandom);
      req_we     = 3'($urandom);
      wb_stall   = ($urandom_range(3) == 0);
      wb_ack     = ($urandom_range(5) == 0);
      wb_data    = DW'($urandom);
      #1;
      e_stall = 3'b111; e_ack = 3'b000; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_addr = '0; e_wd = '0;
      if (mg != 3) begin
        e_stall[mg] = wb_stall;
        e_ack[mg]   = wb_ack;
        e_cyc       = req_cycle[mg];
        e_stb       = req_strobe[mg] & req_cycle[mg];
        e_we        = req_we[mg];
        e_addr      = req_addr[mg];
        e_wd        = req_data[mg];
      end
      n_vec++; if (grant_o !== 2'(mg) || timeout_o !== (mto != 0)) begin
        n_err++; $display("FAIL rnd_state c=%0d got grant=%0d to=%b exp %0d %0d", c, grant_o, timeout_o, mg, mto); end
      n_vec++; if ({req_stall_o, req_ack_o, wb_cycle_o, wb_strobe_o, wb_we_o} !== {e_stall, e_ack, e_cyc, e_stb, e_we}) begin
        n_err++; $display("FAIL rnd_ctrl c=%0d got stall=%b ack=%b cyc=%b stb=%b we=%b exp %b %b %b %b %b",
                          c, req_stall_o, req_ack_o, wb_cycle_o, wb_strobe_o, wb_we_o, e_stall, e_ack, e_cyc, e_stb, e_we); end
      n_vec++; if (wb_addr_o !== e_addr || wb_data_o !== e_wd || req_data_o !== wb_data) begin
        n_err++; $display("FAIL rnd_data c=%0d got addr=%h wd=%h rd=%h exp %h %h %h", c, wb_addr_o, wb_data_o, req_data_o, e_addr, e_wd, wb_data); end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    idle_inputs(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_no_preempt();
    test_read();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
